issue_control_unit: RTL and testbench

ISSUE_CONTROL_UNIT -- requirements
Module: issue_control_unit

---
 rtl/isa_pkg.sv | 40 ++++
 rtl/opcode_decoder.sv | 33 +++
 rtl/issue_control_unit.sv | 108 ++++++++++
 tb/tb_issue_control_unit.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/isa_pkg.sv
// Shared ISA definitions: opcode encodings, control-word bit positions and the control word type.
package isa_pkg;

  typedef logic [15:0] ctrl_word_t;

  localparam logic [3:0] OP_NOP     = 4'h0;
  localparam logic [3:0] OP_ADD     = 4'h1;
  localparam logic [3:0] OP_SUB     = 4'h2;
  localparam logic [3:0] OP_MUL     = 4'h3;
  localparam logic [3:0] OP_LD      = 4'h4;
  localparam logic [3:0] OP_ST      = 4'h5;
  localparam logic [3:0] OP_CMP     = 4'h6;
  localparam logic [3:0] OP_MOV     = 4'h7;
  localparam logic [3:0] OP_OR      = 4'h8;
  localparam logic [3:0] OP_AND     = 4'h9;
  localparam logic [3:0] OP_NOT     = 4'hA;
  localparam logic [3:0] OP_LSL     = 4'hB;
  localparam logic [3:0] OP_UBRANCH = 4'hC;
  localparam logic [3:0] OP_LSR     = 4'hD;
  localparam logic [3:0] OP_BEQ     = 4'hE;
  localparam logic [3:0] OP_BGT     = 4'hF;

  localparam int CB_ADD     = 0;
  localparam int CB_SUB     = 1;
  localparam int CB_MUL     = 2;
  localparam int CB_LD      = 3;
  localparam int CB_ST      = 4;
  localparam int CB_CMP     = 5;
  localparam int CB_MOV     = 6;
  localparam int CB_OR      = 7;
  localparam int CB_AND     = 8;
  localparam int CB_NOT     = 9;
  localparam int CB_LSL     = 10;
  localparam int CB_LSR     = 11;
  localparam int CB_BEQ     = 12;
  localparam int CB_BGT     = 13;
  localparam int CB_WB      = 14;
  localparam int CB_UBRANCH = 15;

endpackage

// File: rtl/opcode_decoder.sv
// Single-lane opcode to control-word decode; purely combinational, zero latency, no flow control.
module opcode_decoder
  import isa_pkg::*;
(
  input  logic [3:0] opcode,
  output ctrl_word_t ctrl,
  output logic       branch
);

  always_comb begin
    ctrl   = '0;
    branch = 1'b0;
    case (opcode)
      OP_ADD:     begin ctrl[CB_ADD] = 1'b1; ctrl[CB_WB] = 1'b1; end
      OP_SUB:     begin ctrl[CB_SUB] = 1'b1; ctrl[CB_WB] = 1'b1; end
      OP_MUL:     begin ctrl[CB_MUL] = 1'b1; ctrl[CB_WB] = 1'b1; end
      OP_LD:      begin ctrl[CB_LD]  = 1'b1; ctrl[CB_WB] = 1'b1; end
      OP_ST:      ctrl[CB_ST]  = 1'b1;
      OP_CMP:     ctrl[CB_CMP] = 1'b1;
      OP_MOV:     begin ctrl[CB_MOV] = 1'b1; ctrl[CB_WB] = 1'b1; end
      OP_OR:      begin ctrl[CB_OR]  = 1'b1; ctrl[CB_WB] = 1'b1; end
      OP_AND:     begin ctrl[CB_AND] = 1'b1; ctrl[CB_WB] = 1'b1; end
      OP_NOT:     begin ctrl[CB_NOT] = 1'b1; ctrl[CB_WB] = 1'b1; end
      OP_LSL:     begin ctrl[CB_LSL] = 1'b1; ctrl[CB_WB] = 1'b1; end
      OP_LSR:     begin ctrl[CB_LSR] = 1'b1; ctrl[CB_WB] = 1'b1; end
      OP_UBRANCH: begin ctrl[CB_UBRANCH] = 1'b1; branch = 1'b1; end
      OP_BEQ:     begin ctrl[CB_BEQ] = 1'b1; branch = 1'b1; end
      OP_BGT:     begin ctrl[CB_BGT] = 1'b1; branch = 1'b1; end
      default:    ctrl = '0;
    endcase
  end

endmodule

// File: rtl/issue_control_unit.sv
// Decode, branch-squash and buffer issue bundles in a DEPTH-entry FIFO; 1-cycle latency, in_ready from occupancy only.
// Optional perf counters (perf_issued, perf_squashed) when ISSUE_CTRL_PERF_EN is defined.
module issue_control_unit
  import isa_pkg::*;
#(
  parameter int ISSUE_W = 2,
  parameter int DEPTH   = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ISSUE_W-1:0]     in_lane_valid,
  input  logic [4*ISSUE_W-1:0]   in_opcode,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ISSUE_W-1:0]     out_lane_valid,
  output logic [16*ISSUE_W-1:0]  out_ctrl
`ifdef ISSUE_CTRL_PERF_EN
  ,
  output logic [31:0]            perf_issued,
  output logic [31:0]            perf_squashed
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  ctrl_word_t              dec_ctrl [ISSUE_W];
  logic [ISSUE_W-1:0]      dec_branch;
  logic [ISSUE_W-1:0]      keep_lv;
  logic [16*ISSUE_W-1:0]   keep_ctrl;
  logic                    branch_seen;

  logic [ISSUE_W-1:0]      mem_lv   [DEPTH];
  logic [16*ISSUE_W-1:0]   mem_ctrl [DEPTH];
  logic [PW-1:0]           rd_ptr, wr_ptr;
  logic [CW-1:0]           count;
  logic                    push, pop;

  for (genvar g = 0; g < ISSUE_W; g++) begin : g_dec
    opcode_decoder u_dec (
      .opcode (in_opcode[4*g +: 4]),
      .ctrl   (dec_ctrl[g]),
      .branch (dec_branch[g])
    );
  end

  // Lanes younger than the oldest valid branch are dropped; the branch itself survives.
  always_comb begin
    keep_lv     = '0;
    keep_ctrl   = '0;
    branch_seen = 1'b0;
    for (int i = 0; i < ISSUE_W; i++) begin
      if (in_lane_valid[i] && !branch_seen) begin
        keep_lv[i]           = 1'b1;
        keep_ctrl[16*i +: 16] = dec_ctrl[i];
        if (dec_branch[i]) branch_seen = 1'b1;
      end
    end
  end

  assign in_ready       = (count < CW'(DEPTH));
  assign out_valid      = (count != '0);
  assign push           = in_valid && in_ready && (|in_lane_valid) && !flush;
  assign pop            = out_valid && out_ready && !flush;
  assign out_lane_valid = out_valid ? mem_lv[rd_ptr]   : '0;
  assign out_ctrl       = out_valid ? mem_ctrl[rd_ptr] : '0;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Entry storage needs no reset: outputs are gated by occupancy.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      mem_lv[wr_ptr]   <= keep_lv;
      mem_ctrl[wr_ptr] <= keep_ctrl;
    end
  end

`ifdef ISSUE_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_issued   <= '0;
      perf_squashed <= '0;
    end else begin
      if (pop)  perf_issued   <= perf_issued + 32'($countones(out_lane_valid));
      if (push) perf_squashed <= perf_squashed + 32'($countones(in_lane_valid & ~keep_lv));
    end
  end
`endif

endmodule

// File: tb/tb_issue_control_unit.sv
// Randomized and directed bench for issue_control_unit against a queue-based reference model.
module tb_issue_control_unit;

  localparam int IW = 2;
  localparam int DP = 2;

  typedef struct packed {
    logic [IW-1:0]    lv;
    logic [16*IW-1:0] ctrl;
  } ent_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [IW-1:0]     in_lane_valid = '0;
  logic [4*IW-1:0]   in_opcode = '0;
  logic              flush = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [IW-1:0]     out_lane_valid;
  logic [16*IW-1:0]  out_ctrl;
`ifdef ISSUE_CTRL_PERF_EN
  logic [31:0]       perf_issued;
  logic [31:0]       perf_squashed;
`endif

  int checks = 0;
  int errors = 0;
  ent_t mq[$];
  logic [31:0] exp_issued = 0;
  logic [31:0] exp_squashed = 0;

  issue_control_unit #(.ISSUE_W(IW), .DEPTH(DP)) dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_lane_valid  (in_lane_valid),
    .in_opcode      (in_opcode),
    .flush          (flush),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_lane_valid (out_lane_valid),
    .out_ctrl       (out_ctrl)
`ifdef ISSUE_CTRL_PERF_EN
    ,
    .perf_issued    (perf_issued),
    .perf_squashed  (perf_squashed)
`endif
  );

  always #5 clk = ~clk;

  // Control word per opcode, straight from the opcode/bit tables.
  function automatic logic [15:0] ref_ctrl(input logic [3:0] op);
    case (op)
      4'h0: return 16'h0000;  4'h1: return 16'h4001;
      4'h2: return 16'h4002;  4'h3: return 16'h4004;
      4'h4: return 16'h4008;  4'h5: return 16'h0010;
      4'h6: return 16'h0020;  4'h7: return 16'h4040;
      4'h8: return 16'h4080;  4'h9: return 16'h4100;
      4'hA: return 16'h4200;  4'hB: return 16'h4400;
      4'hC: return 16'h8000;  4'hD: return 16'h4800;
      4'hE: return 16'h1000;  default: return 16'h2000;
    endcase
  endfunction

  function automatic ent_t ref_bundle(input logic [IW-1:0] lv, input logic [4*IW-1:0] ops,
                                      output int squashed);
    ent_t e;
    int cut;
    logic [3:0] op;
    e = '0;
    cut = IW;
    squashed = 0;
    for (int i = IW - 1; i >= 0; i--) begin
      op = ops[4*i +: 4];
      if (lv[i] && (op == 4'hC || op == 4'hE || op == 4'hF)) cut = i;
    end
    for (int i = 0; i < IW; i++) begin
      if (lv[i] && i <= cut) begin
        e.lv[i] = 1'b1;
        e.ctrl[16*i +: 16] = ref_ctrl(ops[4*i +: 4]);
      end else if (lv[i]) begin
        squashed++;
      end
    end
    return e;
  endfunction

  // Advance one clock and update the reference model from the inputs seen at that edge.
  task automatic step();
    logic do_push, do_pop;
    ent_t e;
    int sq;
    do_push = in_valid && (mq.size() < DP) && (in_lane_valid != '0);
    do_pop  = (mq.size() != 0) && out_ready;
    e = ref_bundle(in_lane_valid, in_opcode, sq);
    @(posedge clk); #1;
    if (reset) begin
      mq.delete();
      exp_issued = 0;
      exp_squashed = 0;
    end else if (flush) begin
      mq.delete();
    end else begin
      if (do_pop) begin
        exp_issued += 32'($countones(mq[0].lv));
        void'(mq.pop_front());
      end
      if (do_push) begin
        mq.push_back(e);
        exp_squashed += 32'(sq);
      end
    end
  endtask

  task automatic drive(input logic v, input logic [IW-1:0] lv, input logic [4*IW-1:0] ops);
    in_valid = v;
    in_lane_valid = lv;
    in_opcode = ops;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b1, 2'b11, 8'h11);
    step();
    reset = 1'b0;
    drive(1'b0, 2'b00, 8'h00);
    checks += 4;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    if (out_lane_valid !== '0) begin errors++; $display("FAIL reset_lane_valid got %b exp 0", out_lane_valid); end
    if (out_ctrl !== '0) begin errors++; $display("FAIL reset_ctrl got %h exp 0", out_ctrl); end
  endtask

  task automatic test_decode_basic();
    out_ready = 1'b1;
    drive(1'b1, 2'b11, 8'h41);
    step();
    drive(1'b0, 2'b00, 8'h00);
    checks += 3;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b exp 1", out_valid); end
    if (out_lane_valid !== 2'b11) begin errors++; $display("FAIL basic_lv got %b exp 11", out_lane_valid); end
    if (out_ctrl !== 32'h4008_4001) begin errors++; $display("FAIL basic_ctrl got %h exp 40084001", out_ctrl); end
    step();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_drain got %b exp 0", out_valid); end
  endtask

  task automatic test_squash();
    logic [31:0] sq0;
    sq0 = exp_squashed;
    out_ready = 1'b0;
    drive(1'b1, 2'b11, 8'h1E);
    step();
    drive(1'b0, 2'b00, 8'h00);
    checks += 2;
    if (out_lane_valid !== 2'b01) begin errors++; $display("FAIL squash_lv got %b exp 01", out_lane_valid); end
    if (out_ctrl !== 32'h0000_1000) begin errors++; $display("FAIL squash_ctrl got %h exp 00001000", out_ctrl); end
`ifdef ISSUE_CTRL_PERF_EN
    checks++;
    if (perf_squashed !== sq0 + 32'd1) begin errors++; $display("FAIL squash_perf got %0d exp %0d", perf_squashed, sq0 + 32'd1); end
`endif
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(1'b1, 2'b11, 8'h21);
    step();
    drive(1'b1, 2'b11, 8'h53);
    step();
    drive(1'b1, 2'b11, 8'h77);
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready got %b exp 0", in_ready); end
    step();
    checks += 2;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_third_ready got %b exp 0", in_ready); end
    if (out_ctrl !== 32'h4002_4001) begin errors++; $display("FAIL bp_head_hold got %h exp 40024001", out_ctrl); end
    drive(1'b0, 2'b00, 8'h00);
    out_ready = 1'b1;
    step();
    checks++;
    if (out_ctrl !== 32'h0010_4004) begin errors++; $display("FAIL bp_second got %h exp 00104004", out_ctrl); end
    step();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got %b exp 0", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(1'b1, 2'b11, 8'h32);
    step();
    step();
    drive(1'b1, 2'b11, 8'hBB);
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks += 2;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %b exp 0", out_valid); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready got %b exp 1", in_ready); end
    drive(1'b0, 2'b00, 8'h00);
    step();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_ghost got %b exp 0", out_valid); end
  endtask

  task automatic test_nop_empty();
    out_ready = 1'b0;
    drive(1'b1, 2'b00, 8'h11);
    step();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL empty_bundle got %b exp 0", out_valid); end
    drive(1'b1, 2'b01, 8'h30);
    step();
    drive(1'b0, 2'b00, 8'h00);
    checks += 2;
    if (out_lane_valid !== 2'b01) begin errors++; $display("FAIL nop_lv got %b exp 01", out_lane_valid); end
    if (out_ctrl !== 32'h0) begin errors++; $display("FAIL nop_ctrl got %h exp 0", out_ctrl); end
    out_ready = 1'b1;
    step();
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0;
    drive(1'b1, 2'b11, 8'h99);
    step();
    reset = 1'b1;
    flush = 1'b1;
    drive(1'b1, 2'b11, 8'h88);
    step();
    reset = 1'b0;
    flush = 1'b0;
    drive(1'b0, 2'b00, 8'h00);
    checks += 4;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_valid got %b exp 0", out_valid); end
    if (out_lane_valid !== '0) begin errors++; $display("FAIL mid_reset_lv got %b exp 0", out_lane_valid); end
    if (out_ctrl !== '0) begin errors++; $display("FAIL mid_reset_ctrl got %h exp 0", out_ctrl); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_ready got %b exp 1", in_ready); end
`ifdef ISSUE_CTRL_PERF_EN
    checks += 2;
    if (perf_issued !== 32'd0) begin errors++; $display("FAIL mid_reset_issued got %0d exp 0", perf_issued); end
    if (perf_squashed !== 32'd0) begin errors++; $display("FAIL mid_reset_squashed got %0d exp 0", perf_squashed); end
`endif
  endtask

  task automatic test_random();
    ent_t head;
    for (int c = 0; c < 400; c++) begin
      drive(1'($urandom_range(0, 1)), IW'($urandom), (4*IW)'($urandom));
      out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 24) == 0);
      reset = ($urandom_range(0, 79) == 0);
      step();
      head = (mq.size() != 0) ? mq[0] : '0;
      checks += 4;
      if (out_valid !== (mq.size() != 0)) begin errors++; $display("FAIL rand_valid cyc %0d got %b exp %b", c, out_valid, mq.size() != 0); end
      if (in_ready !== (mq.size() < DP)) begin errors++; $display("FAIL rand_ready cyc %0d got %b exp %b", c, in_ready, mq.size() < DP); end
      if (out_lane_valid !== head.lv) begin errors++; $display("FAIL rand_lv cyc %0d got %b exp %b", c, out_lane_valid, head.lv); end
      if (out_ctrl !== head.ctrl) begin errors++; $display("FAIL rand_ctrl cyc %0d got %h exp %h", c, out_ctrl, head.ctrl); end
`ifdef ISSUE_CTRL_PERF_EN
      checks += 2;
      if (perf_issued !== exp_issued) begin errors++; $display("FAIL rand_issued cyc %0d got %0d exp %0d", c, perf_issued, exp_issued); end
      if (perf_squashed !== exp_squashed) begin errors++; $display("FAIL rand_squashed cyc %0d got %0d exp %0d", c, perf_squashed, exp_squashed); end
`endif
    end
    reset = 1'b0;
    flush = 1'b0;
    drive(1'b0, 2'b00, 8'h00);
  endtask

  initial begin
    test_reset();
    test_decode_basic();
    test_squash();
    test_backpressure();
    test_flush();
    test_nop_empty();
    test_reset_midstream();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
